// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX boundary: default widths, ALU select codes
// and the operand-forwarding source encoding.
package id_ex_stage_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EXM = 2'b01,
    FWD_MWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of everything crossing the ID/EX boundary: decoded ID fields,
// producer write-back sets, pipeline control and the EX-side outputs.
interface id_ex_stage_if #(
  parameter int XLEN = id_ex_stage_pkg::DEF_XLEN,
  parameter int RA_W = id_ex_stage_pkg::DEF_RA_W
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [3:0]      id_alu_sel;
  logic            id_alu_src;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            exm_reg_write;
  logic [RA_W-1:0] exm_rd;
  logic [XLEN-1:0] exm_result;
  logic            mwb_reg_write;
  logic [RA_W-1:0] mwb_rd;
  logic [XLEN-1:0] mwb_result;
  logic            stall;
  logic            flush;

  logic            load_use_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_sel;
  logic [4:0]      alu_shamt;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [1:0]      fwd_sel_a;
  logic [1:0]      fwd_sel_b;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_alu_sel, id_alu_src, id_reg_write,
           id_mem_read, id_mem_write, exm_reg_write, exm_rd, exm_result,
           mwb_reg_write, mwb_rd, mwb_result, stall, flush,
    input  load_use_stall, ex_valid, ex_pc, alu_a, alu_b, alu_sel, alu_shamt,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_alu_sel, id_alu_src, id_reg_write,
           id_mem_read, id_mem_write, exm_reg_write, exm_rd, exm_result,
           mwb_reg_write, mwb_rd, mwb_result, stall, flush,
    output load_use_stall, ex_valid, ex_pc, alu_a, alu_b, alu_sel, alu_shamt,
           ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           fwd_sel_a, fwd_sel_b
  );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Picks the freshest value for one EX source register: EX/MEM beats MEM/WB,
// which beats the value captured at ID. Register 0 is never forwarded.
module id_ex_stage_forward_unit import id_ex_stage_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic            exm_we_i,
  input  logic [RA_W-1:0] exm_rd_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic            mwb_we_i,
  input  logic [RA_W-1:0] mwb_rd_i,
  input  logic [XLEN-1:0] mwb_result_i,
  input  logic [XLEN-1:0] reg_val_i,
  output logic [XLEN-1:0] operand_o,
  output fwd_sel_e        sel_o
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_we_i && (exm_rd_i != '0) && (exm_rd_i == rs_i);
  assign mwb_hit = mwb_we_i && (mwb_rd_i != '0) && (mwb_rd_i == rs_i);

  always_comb begin
    operand_o = reg_val_i;
    sel_o     = FWD_REG;
    if (exm_hit) begin
      operand_o = exm_result_i;
      sel_o     = FWD_EXM;
    end else if (mwb_hit) begin
      operand_o = mwb_result_i;
      sel_o     = FWD_MWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time MEM/WB bypass, EX-time operand
// forwarding, load-use hazard detection and stall/flush handling.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic                      valid_q, valid_d;
  logic [XLEN-1:0]           pc_q, pc_d;
  logic [XLEN-1:0]           imm_q, imm_d;
  logic [RA_W-1:0]           rd_q, rd_d;
  logic [3:0]                sel_q, sel_d;
  logic                      alu_src_q, alu_src_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [1:0][RA_W-1:0]      rs_q, rs_d;
  logic [1:0][XLEN-1:0]      val_q, val_d;

  logic [1:0][RA_W-1:0]      id_rs;
  logic [1:0][XLEN-1:0]      id_val;
  logic [1:0][XLEN-1:0]      cap_val;
  logic [1:0][XLEN-1:0]      fwd_val;
  fwd_sel_e                  fwd_sel [2];

  logic                      ex_is_load;
  logic                      id_needs_rd;
  logic                      load_use;

  assign id_rs[0]  = bus.id_rs1;
  assign id_rs[1]  = bus.id_rs2;
  assign id_val[0] = bus.id_rs1_data;
  assign id_val[1] = bus.id_rs2_data;

  // Each operand gets the same treatment: a MEM/WB write landing this cycle
  // overrides stale register-file data at capture, then EX-time forwarding.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    assign cap_val[gi] = (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == id_rs[gi]))
                         ? bus.mwb_result : id_val[gi];

    id_ex_stage_forward_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .rs_i         (rs_q[gi]),
      .exm_we_i     (bus.exm_reg_write),
      .exm_rd_i     (bus.exm_rd),
      .exm_result_i (bus.exm_result),
      .mwb_we_i     (bus.mwb_reg_write),
      .mwb_rd_i     (bus.mwb_rd),
      .mwb_result_i (bus.mwb_result),
      .reg_val_i    (val_q[gi]),
      .operand_o    (fwd_val[gi]),
      .sel_o        (fwd_sel[gi])
    );
  end

  assign ex_is_load  = valid_q && mem_read_q && (rd_q != '0);
  assign id_needs_rd = (bus.id_uses_rs1 && (bus.id_rs1 == rd_q)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == rd_q));
  assign load_use    = ex_is_load && id_needs_rd && bus.id_valid && !bus.flush;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    rs_d        = rs_q;
    val_d       = val_q;
    if (bus.flush || (!bus.stall && load_use)) begin
      // Kill or bubble: data fields may keep stale values, only the
      // qualifying bits matter downstream.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      imm_d       = bus.id_imm;
      rd_d        = bus.id_rd;
      sel_d       = bus.id_alu_sel;
      alu_src_d   = bus.id_alu_src;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
      mem_write_d = bus.id_mem_write;
      rs_d        = id_rs;
      val_d       = cap_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      sel_q       <= ALU_ADD;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rs_q        <= '0;
      val_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rs_q        <= rs_d;
      val_q       <= val_d;
    end
  end

  assign bus.load_use_stall = load_use;
  assign bus.ex_valid       = valid_q;
  assign bus.ex_pc          = pc_q;
  assign bus.alu_sel        = sel_q;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_reg_write   = valid_q && reg_write_q;
  assign bus.ex_mem_read    = valid_q && mem_read_q;
  assign bus.ex_mem_write   = valid_q && mem_write_q;
  assign bus.alu_a          = fwd_val[0];
  assign bus.ex_store_data  = fwd_val[1];
  assign bus.alu_b          = alu_src_q ? imm_q : fwd_val[1];
  assign bus.alu_shamt      = alu_src_q ? imm_q[4:0] : fwd_val[1][4:0];
  assign bus.fwd_sel_a      = fwd_sel[0];
  assign bus.fwd_sel_b      = fwd_sel[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios plus random traffic
// checked against an instruction-slot reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus();
  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        id_valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [3:0]  sel;
    logic        src, rw, mr, mw;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_res;
    logic        stall, flush;
  } stim_t;

  // What the EX slot architecturally holds.
  typedef struct {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  sel;
    logic        src, rw, mr, mw;
  } slot_t;

  typedef struct {
    logic        lus, valid;
    logic [31:0] pc, a, b, sd;
    logic [3:0]  sel;
    logic [4:0]  shamt, rd;
    logic        rw, mr, mw;
    logic [1:0]  fa, fb;
  } exp_t;

  exp_t  exp_q[$];
  slot_t ex;
  stim_t cur;
  int    checks = 0;
  int    errors = 0;
  int    txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic slot_t empty_slot();
    slot_t m;
    m = '{default: '0};
    m.sel = ALU_ADD;
    return m;
  endfunction

  // Newest value of register rs visible in EX: {source, value}.
  function automatic logic [33:0] newest(input stim_t s, input logic [4:0] rs, input logic [31:0] held);
    if (rs == 5'd0) return {2'b00, held};
    if (s.exm_we && s.exm_rd == rs) return {2'b01, s.exm_res};
    if (s.mwb_we && s.mwb_rd == rs) return {2'b10, s.mwb_res};
    return {2'b00, held};
  endfunction

  function automatic exp_t predict(input slot_t m, input stim_t s);
    exp_t e;
    logic [33:0] r1, r2;
    logic needs;
    r1 = newest(s, m.rs1, m.v1);
    r2 = newest(s, m.rs2, m.v2);
    needs   = (s.u1 && s.rs1 == m.rd) || (s.u2 && s.rs2 == m.rd);
    e.lus   = m.valid && m.mr && (m.rd != 0) && needs && s.id_valid && !s.flush;
    e.valid = m.valid;
    e.pc    = m.pc;
    e.sel   = m.sel;
    e.rd    = m.rd;
    e.rw    = m.valid && m.rw;
    e.mr    = m.valid && m.mr;
    e.mw    = m.valid && m.mw;
    e.fa    = r1[33:32];
    e.fb    = r2[33:32];
    e.a     = r1[31:0];
    e.sd    = r2[31:0];
    e.b     = m.src ? m.imm : r2[31:0];
    e.shamt = m.src ? m.imm[4:0] : r2[4:0];
    return e;
  endfunction

  function automatic slot_t advance(input slot_t m, input stim_t s, input logic lus);
    slot_t n;
    n = m;
    if (s.flush || (!s.stall && lus)) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else if (!s.stall) begin
      n.valid = s.id_valid; n.pc = s.pc; n.imm = s.imm;
      n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd; n.sel = s.sel;
      n.src = s.src; n.rw = s.rw; n.mr = s.mr; n.mw = s.mw;
      n.v1 = (s.mwb_we && s.mwb_rd != 0 && s.mwb_rd == s.rs1) ? s.mwb_res : s.d1;
      n.v2 = (s.mwb_we && s.mwb_rd != 0 && s.mwb_rd == s.rs2) ? s.mwb_res : s.d2;
    end
    return n;
  endfunction

  task automatic apply(input stim_t s);
    cur = s;
    bus.id_valid = s.id_valid;   bus.id_pc = s.pc;
    bus.id_rs1_data = s.d1;      bus.id_rs2_data = s.d2;   bus.id_imm = s.imm;
    bus.id_rs1 = s.rs1;          bus.id_rs2 = s.rs2;       bus.id_rd = s.rd;
    bus.id_uses_rs1 = s.u1;      bus.id_uses_rs2 = s.u2;
    bus.id_alu_sel = s.sel;      bus.id_alu_src = s.src;
    bus.id_reg_write = s.rw;     bus.id_mem_read = s.mr;   bus.id_mem_write = s.mw;
    bus.exm_reg_write = s.exm_we; bus.exm_rd = s.exm_rd;   bus.exm_result = s.exm_res;
    bus.mwb_reg_write = s.mwb_we; bus.mwb_rd = s.mwb_rd;   bus.mwb_result = s.mwb_res;
    bus.stall = s.stall;         bus.flush = s.flush;
  endtask

  task automatic drive(input stim_t s);
    apply(s);
    exp_q.push_back(predict(ex, s));
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    e  = predict(ex, cur);
    ex = advance(ex, cur, e.lus);
    #1;
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.id_valid = ($urandom_range(0, 3) != 0);
    s.pc = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    s.u1 = 1'($urandom); s.u2 = 1'($urandom);
    s.sel = 4'($urandom_range(0, 15)); s.src = 1'($urandom);
    s.rw = 1'($urandom); s.mr = ($urandom_range(0, 2) == 0); s.mw = ($urandom_range(0, 3) == 0);
    s.exm_we = 1'($urandom); s.exm_rd = 5'($urandom_range(0, 3)); s.exm_res = $urandom;
    s.mwb_we = 1'($urandom); s.mwb_rd = 5'($urandom_range(0, 3)); s.mwb_res = $urandom;
    s.stall = ($urandom_range(0, 5) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Called just after a rising edge with an empty scoreboard queue.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("async_rst_rw", 32'(bus.ex_reg_write), 32'd0);
    chk("async_rst_lus", 32'(bus.load_use_stall), 32'd0);
    ex = empty_slot();
    #4 rst_n = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lus",      32'(bus.load_use_stall), 32'(e.lus));
      chk("ex_valid", 32'(bus.ex_valid),       32'(e.valid));
      chk("ex_pc",    bus.ex_pc,               e.pc);
      chk("alu_a",    bus.alu_a,               e.a);
      chk("alu_b",    bus.alu_b,               e.b);
      chk("store",    bus.ex_store_data,       e.sd);
      chk("alu_sel",  32'(bus.alu_sel),        32'(e.sel));
      chk("shamt",    32'(bus.alu_shamt),      32'(e.shamt));
      chk("ex_rd",    32'(bus.ex_rd),          32'(e.rd));
      chk("reg_wr",   32'(bus.ex_reg_write),   32'(e.rw));
      chk("mem_rd",   32'(bus.ex_mem_read),    32'(e.mr));
      chk("mem_wr",   32'(bus.ex_mem_write),   32'(e.mw));
      chk("fwd_a",    32'(bus.fwd_sel_a),      32'(e.fa));
      chk("fwd_b",    32'(bus.fwd_sel_b),      32'(e.fb));
      $display("txn %0d valid=%0d pc=%h a=%h b=%h shamt=%0d lus=%0d",
               txn, bus.ex_valid, bus.ex_pc, bus.alu_a, bus.alu_b, bus.alu_shamt, bus.load_use_stall);
      txn++;
    end
  end

  initial begin
    stim_t s, t;
    apply(idle());
    ex = empty_slot();
    #11;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_sel",   32'(bus.alu_sel),  32'(ALU_ADD));
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_lus",   32'(bus.load_use_stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.d1 = 5; s.d2 = 7;
    s.u1 = 1; s.u2 = 1; s.rw = 1; s.sel = ALU_ADD; s.pc = 32'h100;
    drive(s); tick();
    drive(idle()); #1;
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_a", bus.alu_a, 32'd5);
    chk("add_b", bus.alu_b, 32'd7);
    chk("add_rd", 32'(bus.ex_rd), 32'd3);
    chk("add_rw", 32'(bus.ex_reg_write), 32'd1);
    tick();

    // Forwarding priority with EX held by stall
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.u1 = 1; s.d1 = 32'h11; s.rd = 4; s.rw = 1;
    drive(s); tick();
    t = idle(); t.stall = 1;
    t.exm_we = 1; t.exm_rd = 1; t.exm_res = 32'h10;
    t.mwb_we = 1; t.mwb_rd = 1; t.mwb_res = 32'h20;
    drive(t); #1; chk("fwd_exm", bus.alu_a, 32'h10); tick();
    t.exm_we = 0;
    drive(t); #1; chk("fwd_mwb", bus.alu_a, 32'h20); tick();
    t.exm_we = 1; t.exm_rd = 0; t.exm_res = 32'hFF; t.mwb_we = 0;
    drive(t); #1; chk("fwd_rd0", bus.alu_a, 32'h11); tick();

    // Load-use: lw x5 then sub x6,x5,x1
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.u1 = 1; s.rd = 5; s.mr = 1; s.rw = 1;
    s.src = 1; s.imm = 8;
    drive(s); tick();
    t = idle(); t.id_valid = 1; t.rs1 = 5; t.rs2 = 1; t.rd = 6; t.u1 = 1; t.u2 = 1;
    t.rw = 1; t.sel = ALU_SUB; t.d1 = 32'h999; t.d2 = 3; t.pc = 32'h200;
    drive(t); #1; chk("lu_stall", 32'(bus.load_use_stall), 32'd1); tick();
    t.exm_we = 1; t.exm_rd = 5; t.exm_res = 32'h100;
    drive(t); #1;
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(bus.ex_reg_write), 32'd0);
    tick();
    s = idle(); s.mwb_we = 1; s.mwb_rd = 5; s.mwb_res = 32'hABCD;
    drive(s); #1; chk("lu_fwd_a", bus.alu_a, 32'hABCD); tick();

    // Flush overrides load-use
    s = idle(); s.id_valid = 1; s.rd = 5; s.mr = 1; s.rw = 1;
    drive(s); tick();
    t = idle(); t.id_valid = 1; t.rs1 = 5; t.u1 = 1; t.mw = 1; t.flush = 1;
    drive(t); #1; chk("flush_lus", 32'(bus.load_use_stall), 32'd0); tick();
    drive(idle()); #1;
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_mw", 32'(bus.ex_mem_write), 32'd0);
    tick();

    // Stall holds EX for three cycles
    s = idle(); s.id_valid = 1; s.pc = 32'h40; s.d1 = 32'h77; s.rs1 = 2; s.rw = 1; s.rd = 7;
    drive(s); tick();
    for (int i = 0; i < 3; i++) begin
      t = rnd(); t.stall = 1; t.flush = 0; t.pc = 32'h1000 + i;
      t.exm_we = 0; t.mwb_we = 0;
      drive(t); #1; chk("stall_pc", bus.ex_pc, 32'h40); tick();
    end
    s = idle(); s.id_valid = 1; s.pc = 32'h80;
    drive(s); tick();
    drive(idle()); #1; chk("release_pc", bus.ex_pc, 32'h80); tick();

    // Shift amount from immediate, then from forwarded rs2
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.u1 = 1; s.rd = 2; s.src = 1; s.imm = 4;
    s.sel = ALU_SLL; s.rw = 1;
    drive(s); tick();
    drive(idle()); #1; chk("slli_shamt", 32'(bus.alu_shamt), 32'd4); tick();
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 3; s.u1 = 1; s.u2 = 1; s.rd = 2;
    s.sel = ALU_SLL; s.rw = 1;
    drive(s); tick();
    t = idle(); t.exm_we = 1; t.exm_rd = 3; t.exm_res = 32'h25;
    drive(t); #1; chk("sll_shamt", 32'(bus.alu_shamt), 32'd5); tick();

    // Random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) mid_reset();
      drive(rnd());
      tick();
    end
    drive(idle());
    tick();
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
